bch_chien_search: RTL and testbench
===================================

Name: bch_chien_search

Overview:
- Downstream stage of the parallel inversionless BMA sigma solver; consumes its sigma polynomial and err_count.
- Performs a bit-serial Chien search over the data portion of the (possibly shortened) codeword.
- Emits one error-flag bit per data bit in transmission order, with output backpressure.
- Reports the number of roots found and a decode-failure flag when that number disagrees with err_count.

Parameters:
- P, `BCH_SANE, packed BCH parameter word.
- Derived localparams:
  - M = `BCH_M(P)
  - T = `BCH_T(P)
  - K = `BCH_DATA_BITS(P)
  - NE = K + `BCH_ECC_BITS(P), the effective codeword length.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  load sigma/err_count; accepted only when ready=1
- sigma  in  `BCH_SIGMA_SZ(P)  coefficients sigma_0..sigma_T, M bits each, sigma_0 at LSB; any nonzero scaling allowed
- err_count  in  `BCH_ERR_SZ(P)  degree expected by BMA
- ready  out  1  can accept start
- out_valid  out  1  err_bit valid
- out_ready  in  1  downstream accepts err_bit
- err_bit  out  1  1 = data bit k is in error
- first  out  1  qualifies k=0
- last  out  1  qualifies k=K-1
- done  out  1  search complete, results held
- ack_done  in  1  releases done
- found  out  `BCH_ERR_SZ(P)  roots found in data bits
- fail  out  1  found != err_count, or err_count > T

Behaviour:
- Reset (async): state=IDLE. ready=1, out_valid=0, err_bit=0, first=0, last=0, done=0, found=0, fail=0. All coefficient registers are 0.
- States:
  - IDLE -> LOAD on start&ready.
  - LOAD -> SEARCH after 1 cycle.
  - SEARCH -> DONE on the handshake of k=K-1.
  - DONE -> IDLE on ack_done.
  - ready = (state==IDLE) || (state==DONE && ack_done). A start accepted from DONE acts as ack plus start in the same cycle.
- start while not ready is ignored. The inputs are sampled only on the accepting edge; the upstream block may change them afterwards.
- LOAD: for each j=1..T, set r_j = sigma_j * alpha^(j*(2^M-1-NE+1)) mod (2^M-1), using constant multipliers from bch.vh. r_0 = sigma_0. Clear found; latch err_count.
- Evaluation: S = r_0 ^ r_1 ^ ... ^ r_T, which equals sigma(alpha^(2^M-NE+k)). Data bit k has exponent NE-1-k. err_bit = (S==0) for the current k.
- SEARCH:
  - out_valid=1 for the whole state.
  - On out_valid&out_ready: each r_j <= r_j*alpha^j; k++; found += err_bit, saturating at T.
  - Without out_ready, all registers hold and err_bit/first/last stay stable.
- Latency: first out_valid occurs 2 clocks after the start edge. With out_ready held high, k=K-1 appears K+1 clocks after start. done rises on the clock after the last handshake.
- fail is computed on entry to DONE, using the final found including bit K-1. An err_bit on the last handshake is counted.
- Parity-bit positions are not searched. Roots located in the ECC region are therefore counted as mismatch and set fail.
- sigma all-zero: every k flags an error, found saturates at T, and fail=1.
- reset mid-search: returns to IDLE immediately, out_valid=0 asynchronously, and no done pulse.
- ack_done without done: no effect.

Decomposition:
- Shared bch.vh functions (not a new package): alpha-power constant multiplier generation and the field exponent helper; the initial-offset exponent table is a localparam array.
- One natural sub-module, bch_chien_reg: a single r_j register with a load mux, a constant alpha^j step multiplier, and a load-time constant alpha^(j*offset) multiplier. Instantiate it as an array [T:1].
- Reuse finite_parallel_adder for S.

Test Plan:
- All tests use (15,7) T=2, M=4, K=7, NE=15.
- sigma={0,0,1} (no error), err_count=0, out_ready=1:
  - 7 beats, all err_bit=0
  - first on beat 0, last on beat 6
  - found=0, fail=0
  - done exactly 1 clock after beat 6
- Single error at data bit 0 (exponent 14), sigma=1+alpha^14·x scaled by alpha^3, err_count=1:
  - err_bit=1 only on beat 0
  - found=1, fail=0
- Two errors at data bits 2 and 6:
  - sigma from the bch_sigma_bma_parallel golden model, err_count=2
  - err_bit on beats 2 and 6 only
  - found=2, fail=0
- Error located in a parity bit (exponent 3), err_count=1:
  - no err_bit asserted
  - found=0, fail=1
- Backpressure: toggle out_ready 1,0,0,1 randomly:
  - err_bit sequence is identical to the no-stall run
  - outputs stable while stalled
  - total beats = 7
- reset asserted at beat 3, then start again:
  - out_valid drops asynchronously and no done pulse
  - the second search completes correctly
- start held during SEARCH is ignored.
- ack_done and start in the same cycle in DONE: a new search begins with first out_valid 2 clocks later.

Source files
------------

// File: rtl/bch_chien_search_pkg.sv
// Shared BCH helpers: parameter-word decoding, GF(2^m) constant arithmetic, FSM state type.
// Latency: n/a (compile-time functions and types only).
// Backpressure: n/a.
//
// Parameter word layout: [7:0] = M (field degree), [15:8] = T (correctable errors),
// [31:16] = K (data bits). ECC bits of a binary BCH code are taken as M*T.
package bch_chien_search_pkg;

  localparam int GF_MAX = 16;

  // (15,7) double-error-correcting code over GF(16).
  localparam logic [31:0] BCH_SANE = {16'd7, 8'd2, 8'd4};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_DONE
  } chien_state_t;

  function automatic int bch_m(input logic [31:0] p);
    return int'(p[7:0]);
  endfunction

  function automatic int bch_t(input logic [31:0] p);
    return int'(p[15:8]);
  endfunction

  function automatic int bch_data_bits(input logic [31:0] p);
    return int'(p[31:16]);
  endfunction

  function automatic int bch_ecc_bits(input logic [31:0] p);
    return bch_m(p) * bch_t(p);
  endfunction

  function automatic int bch_sigma_sz(input logic [31:0] p);
    return bch_m(p) * (bch_t(p) + 1);
  endfunction

  // Wide enough to hold the values 0..T.
  function automatic int bch_err_sz(input logic [31:0] p);
    return (bch_t(p) < 2) ? 1 : $clog2(bch_t(p) + 1);
  endfunction

  // Primitive polynomial per field degree, including the x^m term.
  function automatic logic [GF_MAX:0] gf_poly(input int m);
    logic [GF_MAX:0] poly;
    case (m)
      3:       poly = 17'h0000b;
      4:       poly = 17'h00013;
      5:       poly = 17'h00025;
      6:       poly = 17'h00043;
      7:       poly = 17'h00089;
      8:       poly = 17'h0011d;
      9:       poly = 17'h00211;
      10:      poly = 17'h00409;
      default: poly = 17'h00013;
    endcase
    return poly;
  endfunction

  function automatic logic [GF_MAX-1:0] gf_mul_alpha(input logic [GF_MAX-1:0] a, input int m);
    logic [GF_MAX:0] x;
    x = {a, 1'b0};
    if (x[m]) x = x ^ gf_poly(m);
    return x[GF_MAX-1:0];
  endfunction

  // Field exponent helper: reduce an exponent modulo the multiplicative group order.
  function automatic int gf_exp_mod(input int e, input int m);
    return e % ((1 << m) - 1);
  endfunction

  // alpha^e in polynomial basis.
  function automatic logic [GF_MAX-1:0] gf_pow(input int e, input int m);
    logic [GF_MAX-1:0] a;
    a = 16'd1;
    for (int i = 0; i < gf_exp_mod(e, m); i++) a = gf_mul_alpha(a, m);
    return a;
  endfunction

endpackage

// File: rtl/bch_chien_reg.sv
// One Chien term register r_j: load raw sigma_j, scale by alpha^LOAD_EXP once, then step by alpha^J.
// Latency: 1 clock per operation.
// Backpressure: holds its value when no control is asserted.
//
// Ports: clk, reset (async, active high), load/scale/step controls (load has priority),
// d = raw sigma_j coefficient, q = current term value.
module bch_chien_reg import bch_chien_search_pkg::*; #(
  parameter int M        = 4,
  parameter int J        = 1,
  parameter int LOAD_EXP = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         scale,
  input  logic         step,
  input  logic [M-1:0] d,
  output logic [M-1:0] q
);

  logic [M-1:0] scale_term [M];
  logic [M-1:0] step_term  [M];
  logic [M-1:0] scaled;
  logic [M-1:0] stepped;

  // Constant multiply as a GF(2) matrix: column i is alpha^(e+i), selected by bit i of q.
  for (genvar i = 0; i < M; i++) begin : g_col
    localparam logic [GF_MAX-1:0] SCALE_COL = gf_pow(LOAD_EXP + i, M);
    localparam logic [GF_MAX-1:0] STEP_COL  = gf_pow(J + i, M);
    assign scale_term[i] = q[i] ? SCALE_COL[M-1:0] : '0;
    assign step_term[i]  = q[i] ? STEP_COL[M-1:0]  : '0;
  end

  always_comb begin
    scaled  = '0;
    stepped = '0;
    for (int i = 0; i < M; i++) begin
      scaled  = scaled ^ scale_term[i];
      stepped = stepped ^ step_term[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (scale) begin
      q <= scaled;
    end else if (step) begin
      q <= stepped;
    end
  end

endmodule

// File: rtl/finite_parallel_adder.sv
// GF(2^m) adder: XOR of N packed M-bit terms, term 0 at the LSB.
// Latency: combinational.
// Backpressure: none.
//
// Ports: terms (N*M bits in), sum (M bits out).
module finite_parallel_adder #(
  parameter int M = 4,
  parameter int N = 3
) (
  input  logic [M*N-1:0] terms,
  output logic [M-1:0]   sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum ^ terms[i*M +: M];
  end

endmodule

// File: rtl/bch_chien_search.sv
// Bit-serial Chien search over the data bits of a (shortened) BCH codeword; one error flag per data bit.
// Latency: first out_valid 2 clocks after start is driven (1 accept edge + 1 LOAD cycle); done 1 clock after last beat.
// Backpressure: out_valid/out_ready; without out_ready every register holds and outputs stay stable.
//
// Ports: clk, reset (async, active high); start/ready accept sigma + err_count;
// out_valid/out_ready/err_bit/first/last stream one flag per data bit in transmission order;
// done/ack_done hold and release the result; found = roots seen in data bits; fail = found != err_count,
// err_count > T, or a degenerate sigma (sigma_0 == 0).
module bch_chien_search import bch_chien_search_pkg::*; #(
  parameter logic [31:0] P = BCH_SANE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [bch_sigma_sz(P)-1:0] sigma,
  input  logic [bch_err_sz(P)-1:0]   err_count,
  output logic                       ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       err_bit,
  output logic                       first,
  output logic                       last,
  output logic                       done,
  input  logic                       ack_done,
  output logic [bch_err_sz(P)-1:0]   found,
  output logic                       fail
);

  localparam int M      = bch_m(P);
  localparam int T      = bch_t(P);
  localparam int K      = bch_data_bits(P);
  localparam int NE     = K + bch_ecc_bits(P);
  localparam int NN     = (1 << M) - 1;
  // Starting exponent so that beat k evaluates sigma at alpha^(2^M-NE+k), i.e. data bit k
  // (exponent NE-1-k) is tested first for the earliest-transmitted bit.
  localparam int OFFSET = (1 << M) - NE;
  localparam int EW     = bch_err_sz(P);
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [EW-1:0] T_MAX  = EW'(T);

  chien_state_t state, state_d;

  logic [M-1:0]       r0;
  logic [M*(T+1)-1:0] r_all;
  logic [M-1:0]       s_sum;
  logic [KW-1:0]      k;
  logic [EW-1:0]      err_cnt_q;
  logic [EW-1:0]      found_inc;
  logic               fail_d;
  logic               accept;
  logic               hs;

  assign accept = start & ready;
  assign hs     = out_valid & out_ready;

  // sigma_0 needs no scaling and never steps (alpha^0), so it lives here as a plain register.
  assign r_all[M-1:0] = r0;

  for (genvar j = 1; j <= T; j++) begin : g_reg
    bch_chien_reg #(
      .M        (M),
      .J        (j),
      .LOAD_EXP ((j * OFFSET) % NN)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .scale (state == S_LOAD),
      .step  (hs),
      .d     (sigma[j*M +: M]),
      .q     (r_all[j*M +: M])
    );
  end

  finite_parallel_adder #(
    .M (M),
    .N (T + 1)
  ) u_sum (
    .terms (r_all),
    .sum   (s_sum)
  );

  always_comb begin
    state_d   = state;
    ready     = 1'b0;
    out_valid = 1'b0;
    err_bit   = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        out_valid = 1'b1;
        err_bit   = (s_sum == '0);
        first     = (k == '0);
        last      = (k == K_LAST);
        if (out_ready && (k == K_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        done  = 1'b1;
        // Releasing done frees the block in the same cycle, so ack+start chains searches.
        ready = ack_done;
        if (ack_done) state_d = start ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    found_inc = found;
    if (err_bit && (found != T_MAX)) found_inc = found + 1'b1;
  end

  // A zero sigma_0 means no valid locator (e.g. all-zero sigma flags every bit), so it always fails.
  assign fail_d = (found_inc != err_cnt_q) || (err_cnt_q > T_MAX) || (r0 == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      r0        <= '0;
      err_cnt_q <= '0;
      k         <= '0;
      found     <= '0;
      fail      <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        r0        <= sigma[M-1:0];
        err_cnt_q <= err_count;
      end
      if (state == S_LOAD) begin
        k     <= '0;
        found <= '0;
        fail  <= 1'b0;
      end else if (hs) begin
        k     <= k + 1'b1;
        found <= found_inc;
        if (k == K_LAST) fail <= fail_d;
      end
    end
  end

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed bench for bch_chien_search on the (15,7) T=2 code over GF(16), x^4+x+1.
// Beat k evaluates sigma at alpha^(1+k); an error at exponent e is flagged on beat 14-e.
module tb_bch_chien_search;
  import bch_chien_search_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] sigma;
  logic [1:0]  err_count;
  logic        ready;
  logic        out_valid;
  logic        out_ready;
  logic        err_bit;
  logic        first;
  logic        last;
  logic        done;
  logic        ack_done;
  logic [1:0]  found;
  logic        fail;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the most recent run_search call.
  logic [6:0] cap_bits;
  logic [6:0] cap_first;
  logic [6:0] cap_last;
  int         cap_beats;
  int         cap_lat;
  int         cap_gap;
  int         cap_unstable;
  bit         cap_timeout;
  logic [1:0] cap_found;
  logic       cap_fail;

  always #5 clk = ~clk;

  bch_chien_search #(.P(BCH_SANE)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sigma     (sigma),
    .err_count (err_count),
    .ready     (ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_bit   (err_bit),
    .first     (first),
    .last      (last),
    .done      (done),
    .ack_done  (ack_done),
    .found     (found),
    .fail      (fail)
  );

  // Drives one search and records what the DUT emits; cycle 0 is the cycle start is high.
  // Inputs are scrambled after the accepting edge to show they are sampled only there.
  task automatic run_search(input logic [11:0] sig, input logic [1:0] ec, input bit stall,
                            input bit with_ack, input bit do_ack, input bit hold_start);
    int   last_cyc;
    bit   done_seen;
    bit   prev_stall;
    logic [2:0] prev_out;
    logic [3:0] rdy_pat;
    rdy_pat      = 4'b1001;
    cap_bits     = '0;
    cap_first    = '0;
    cap_last     = '0;
    cap_beats    = 0;
    cap_lat      = -1;
    cap_gap      = -1;
    cap_unstable = 0;
    cap_found    = 'x;
    cap_fail     = 1'bx;
    last_cyc     = -1;
    done_seen    = 0;
    prev_stall   = 0;
    prev_out     = '0;
    @(posedge clk); #1;
    start     = 1'b1;
    sigma     = sig;
    err_count = ec;
    ack_done  = with_ack;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (cap_lat < 0) cap_lat = c;
        if (prev_stall && ({err_bit, first, last} !== prev_out)) cap_unstable++;
        if (out_ready) begin
          if (cap_beats < 7) begin
            cap_bits[cap_beats]  = err_bit;
            cap_first[cap_beats] = first;
            cap_last[cap_beats]  = last;
          end
          cap_beats++;
          last_cyc   = c;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_out   = {err_bit, first, last};
        end
      end
      if (done && last_cyc >= 0) begin
        done_seen = 1;
        cap_gap   = c - last_cyc;
        cap_found = found;
        cap_fail  = fail;
      end
      @(posedge clk); #1;
      start     = hold_start && !done_seen;
      ack_done  = 1'b0;
      sigma     = 12'hfff;
      err_count = 2'd3;
      out_ready = stall ? rdy_pat[(c + 1) % 4] : 1'b1;
    end
    cap_timeout = !done_seen;
    if (do_ack) begin
      ack_done = 1'b1;
      @(posedge clk); #1;
      ack_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL reset.ready got=%b exp=1", ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got=%b exp=0", out_valid); end
    n_tests++;
    if ({err_bit, first, last, done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset.flags got=%b exp=0000", {err_bit, first, last, done});
    end
    n_tests++;
    if ({found, fail} !== 3'b000) begin n_fail++; $display("FAIL reset.result got=%b exp=000", {found, fail}); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_no_error();
    run_search(12'h001, 2'd0, 0, 0, 1, 0);
    n_tests++;
    if (cap_timeout) begin n_fail++; $display("FAIL noerr.timeout got=no_done exp=done"); end
    n_tests++;
    if (cap_beats != 7) begin n_fail++; $display("FAIL noerr.beats got=%0d exp=7", cap_beats); end
    n_tests++;
    if (cap_bits !== 7'b0000000) begin n_fail++; $display("FAIL noerr.bits got=%b exp=0000000", cap_bits); end
    n_tests++;
    if (cap_first !== 7'b0000001) begin n_fail++; $display("FAIL noerr.first got=%b exp=0000001", cap_first); end
    n_tests++;
    if (cap_last !== 7'b1000000) begin n_fail++; $display("FAIL noerr.last got=%b exp=1000000", cap_last); end
    n_tests++;
    if (cap_lat != 2) begin n_fail++; $display("FAIL noerr.latency got=%0d exp=2", cap_lat); end
    n_tests++;
    if (cap_gap != 1) begin n_fail++; $display("FAIL noerr.done_gap got=%0d exp=1", cap_gap); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b000) begin
      n_fail++; $display("FAIL noerr.result got=%b exp=000", {cap_found, cap_fail});
    end
  endtask

  // Error at exponent 14: sigma = alpha^3 * (1 + alpha^14 x) = 8 + 4x.
  task automatic test_single_error();
    run_search(12'h048, 2'd1, 0, 0, 1, 0);
    n_tests++;
    if (cap_timeout) begin n_fail++; $display("FAIL single.timeout got=no_done exp=done"); end
    n_tests++;
    if (cap_bits !== 7'b0000001) begin n_fail++; $display("FAIL single.bits got=%b exp=0000001", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b010) begin
      n_fail++; $display("FAIL single.result got=%b exp=010", {cap_found, cap_fail});
    end
  endtask

  // Errors at exponents 12 and 8: sigma = 1 + alpha^9 x + alpha^5 x^2 = {6, A, 1}.
  task automatic test_two_errors();
    run_search(12'h6a1, 2'd2, 0, 0, 1, 0);
    n_tests++;
    if (cap_timeout) begin n_fail++; $display("FAIL two.timeout got=no_done exp=done"); end
    n_tests++;
    if (cap_bits !== 7'b1000100) begin n_fail++; $display("FAIL two.bits got=%b exp=1000100", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b100) begin
      n_fail++; $display("FAIL two.result got=%b exp=100", {cap_found, cap_fail});
    end
  endtask

  // Error at exponent 3 (parity region): sigma = 1 + alpha^3 x.
  task automatic test_parity_error();
    run_search(12'h081, 2'd1, 0, 0, 1, 0);
    n_tests++;
    if (cap_bits !== 7'b0000000) begin n_fail++; $display("FAIL parity.bits got=%b exp=0000000", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b001) begin
      n_fail++; $display("FAIL parity.result got=%b exp=001", {cap_found, cap_fail});
    end
  endtask

  task automatic test_zero_sigma();
    run_search(12'h000, 2'd2, 0, 0, 1, 0);
    n_tests++;
    if (cap_bits !== 7'b1111111) begin n_fail++; $display("FAIL zero.bits got=%b exp=1111111", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b101) begin
      n_fail++; $display("FAIL zero.result got=%b exp=101", {cap_found, cap_fail});
    end
  endtask

  task automatic test_err_count_over_t();
    run_search(12'h001, 2'd3, 0, 0, 1, 0);
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b001) begin
      n_fail++; $display("FAIL over_t.result got=%b exp=001", {cap_found, cap_fail});
    end
  endtask

  task automatic test_backpressure();
    run_search(12'h6a1, 2'd2, 1, 0, 1, 0);
    n_tests++;
    if (cap_timeout) begin n_fail++; $display("FAIL bp.timeout got=no_done exp=done"); end
    n_tests++;
    if (cap_beats != 7) begin n_fail++; $display("FAIL bp.beats got=%0d exp=7", cap_beats); end
    n_tests++;
    if (cap_bits !== 7'b1000100) begin n_fail++; $display("FAIL bp.bits got=%b exp=1000100", cap_bits); end
    n_tests++;
    if (cap_unstable != 0) begin n_fail++; $display("FAIL bp.stable got=%0d changes exp=0", cap_unstable); end
    n_tests++;
    if (cap_gap != 1) begin n_fail++; $display("FAIL bp.done_gap got=%0d exp=1", cap_gap); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b100) begin
      n_fail++; $display("FAIL bp.result got=%b exp=100", {cap_found, cap_fail});
    end
  endtask

  task automatic test_reset_mid_search();
    int  idx;
    bit  hit;
    bit  seen_bad;
    idx      = 0;
    hit      = 0;
    seen_bad = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    sigma     = 12'h6a1;
    err_count = 2'd2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (idx == 3) hit = 1;
        else idx++;
      end
    end
    n_tests++;
    if (!hit) begin n_fail++; $display("FAIL rst_mid.reach_beat3 got=beat%0d exp=beat3", idx); end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, ready} !== 2'b01) begin
      n_fail++; $display("FAIL rst_mid.async got=%b exp=01 (out_valid,ready)", {out_valid, ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || out_valid) seen_bad = 1;
    end
    n_tests++;
    if (seen_bad) begin n_fail++; $display("FAIL rst_mid.quiet got=activity exp=none"); end
    run_search(12'h048, 2'd1, 0, 0, 1, 0);
    n_tests++;
    if (cap_bits !== 7'b0000001) begin n_fail++; $display("FAIL rst_mid.rerun_bits got=%b exp=0000001", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b010) begin
      n_fail++; $display("FAIL rst_mid.rerun_result got=%b exp=010", {cap_found, cap_fail});
    end
  endtask

  task automatic test_start_held();
    run_search(12'h048, 2'd1, 0, 0, 1, 1);
    n_tests++;
    if (cap_beats != 7) begin n_fail++; $display("FAIL held.beats got=%0d exp=7", cap_beats); end
    n_tests++;
    if (cap_bits !== 7'b0000001) begin n_fail++; $display("FAIL held.bits got=%b exp=0000001", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b010) begin
      n_fail++; $display("FAIL held.result got=%b exp=010", {cap_found, cap_fail});
    end
  endtask

  task automatic test_ack_and_start();
    run_search(12'h6a1, 2'd2, 0, 0, 0, 0);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL ackstart.done_held got=%b exp=1", done); end
    run_search(12'h048, 2'd1, 0, 1, 1, 0);
    n_tests++;
    if (cap_lat != 2) begin n_fail++; $display("FAIL ackstart.latency got=%0d exp=2", cap_lat); end
    n_tests++;
    if (cap_bits !== 7'b0000001) begin n_fail++; $display("FAIL ackstart.bits got=%b exp=0000001", cap_bits); end
    n_tests++;
    if ({cap_found, cap_fail} !== 3'b010) begin
      n_fail++; $display("FAIL ackstart.result got=%b exp=010", {cap_found, cap_fail});
    end
  endtask

  task automatic test_ack_without_done();
    @(posedge clk); #1;
    ack_done = 1'b1;
    @(posedge clk); #1;
    ack_done = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ready, out_valid, done} !== 3'b100) begin
      n_fail++; $display("FAIL ack_idle got=%b exp=100 (ready,out_valid,done)", {ready, out_valid, done});
    end
  endtask

  initial begin
    start     = 1'b0;
    ack_done  = 1'b0;
    out_ready = 1'b0;
    sigma     = '0;
    err_count = '0;
    test_reset();
    test_no_error();
    test_single_error();
    test_two_errors();
    test_parity_error();
    test_zero_sigma();
    test_err_count_over_t();
    test_backpressure();
    test_reset_mid_search();
    test_start_held();
    test_ack_and_start();
    test_ack_without_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
